neuron_mac_sequencer: RTL and testbench

//   Computes one neuron: y = act(sum_{i<N_IN} W[i]*X[i] + BIAS).

---
 rtl/neuron_mac_sequencer_if.sv | 30 +++
 rtl/neuron_mac_sequencer.sv | 146 ++++++++++++++
 tb/tb_neuron_mac_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_sequencer_if.sv
// Bundle of neuron sequencer signals: control, dual BRAM read ports and output handshake.
// master = sequencer side, slave = the BRAMs plus upstream/downstream logic.
interface neuron_mac_sequencer_if #(
    parameter int AW = 5,
    parameter int DW = 16
) ();
    logic          start;
    logic [DW-1:0] bias;
    logic          busy;
    logic [AW-1:0] w_addr;
    logic          w_en;
    logic          w_we;
    logic [DW-1:0] w_do;
    logic [AW-1:0] x_addr;
    logic          x_en;
    logic [DW-1:0] x_do;
    logic [DW-1:0] y;
    logic          y_valid;
    logic          y_ready;

    modport master (
        input  start, bias, w_do, x_do, y_ready,
        output busy, w_addr, w_en, w_we, x_addr, x_en, y, y_valid
    );

    modport slave (
        output start, bias, w_do, x_do, y_ready,
        input  busy, w_addr, w_en, w_we, x_addr, x_en, y, y_valid
    );
endinterface

// File: rtl/neuron_mac_sequencer.sv
// One neuron: sweeps weight/feature BRAMs, 2-stage MAC, then bias, saturate and optional ReLU.
//   state    | meaning
//   S_IDLE   | waiting for start
//   S_FETCH  | addresses 0..N_IN-1 issued, products captured and accumulated
//   S_DRAIN  | last product folded into the accumulator
//   S_FINISH | bias add, scale, saturate, activation into y
//   S_OUT    | y_valid held until y_ready
module neuron_mac_sequencer #(
    parameter int N_IN  = 28,
    parameter int AW    = 5,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 40,
    parameter bit RELU  = 1'b1
) (
    input logic                    clk,
    input logic                    rst,
    neuron_mac_sequencer_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_FINISH, S_OUT} state_t;

    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((64'sd1 <<< (DW-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    state_t                    state, state_nxt;
    logic [AW-1:0]             addr;
    logic                      en;
    logic signed [DW-1:0]      bias_q;
    logic signed [2*DW-1:0]    prod;
    logic                      pvalid;
    logic signed [ACC_W-1:0]   acc;
    logic [DW-1:0]             y_q;
    logic                      y_valid_q;
    logic                      busy_q;

    logic                      last_fetch;
    logic signed [2*DW-1:0]    w_ext, x_ext, prod_nxt;
    logic signed [ACC_W-1:0]   prod_ext, bias_ext, sum_full, shifted;
    logic [DW-1:0]             y_sat, y_fin;

    assign last_fetch  = (addr == AW'(N_IN-1));

    assign bus.w_addr  = addr;
    assign bus.x_addr  = addr;
    assign bus.w_en    = en;
    assign bus.x_en    = en;
    assign bus.w_we    = 1'b0;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.busy    = busy_q;

    always_comb begin
        w_ext    = {{DW{bus.w_do[DW-1]}}, bus.w_do};
        x_ext    = {{DW{bus.x_do[DW-1]}}, bus.x_do};
        prod_nxt = w_ext * x_ext;
        prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        bias_ext = {{(ACC_W-DW){bias_q[DW-1]}}, bias_q};
        sum_full = acc + (bias_ext <<< FRAC);
        // arithmetic shift: drops fraction rounding toward -inf
        shifted  = sum_full >>> FRAC;
        if (shifted > Y_MAX) begin
            y_sat = {1'b0, {(DW-1){1'b1}}};
        end else if (shifted < Y_MIN) begin
            y_sat = {1'b1, {(DW-1){1'b0}}};
        end else begin
            y_sat = shifted[DW-1:0];
        end
        if (RELU && y_sat[DW-1]) begin
            y_fin = '0;
        end else begin
            y_fin = y_sat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_FETCH;
            S_FETCH:  if (last_fetch) state_nxt = S_DRAIN;
            S_DRAIN:  state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_OUT;
            S_OUT:    if (bus.y_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            en        <= 1'b0;
            bias_q    <= '0;
            prod      <= '0;
            pvalid    <= 1'b0;
            acc       <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        bias_q <= bus.bias;
                        addr   <= '0;
                        en     <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    prod   <= prod_nxt;
                    pvalid <= 1'b1;
                    if (pvalid) acc <= acc + prod_ext;
                    if (last_fetch) begin
                        en   <= 1'b0;
                        addr <= '0;
                    end else begin
                        addr <= addr + AW'(1);
                    end
                end
                S_DRAIN: begin
                    acc    <= acc + prod_ext;
                    pvalid <= 1'b0;
                end
                S_FINISH: begin
                    y_q       <= y_fin;
                    y_valid_q <= 1'b1;
                end
                S_OUT: begin
                    if (bus.y_ready) begin
                        y_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Drives a ReLU and a linear instance side by side from shared BRAM contents and
// compares both against a plain-arithmetic neuron model.
module tb_neuron_mac_sequencer;
    localparam int N = 28;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [15:0] bias_v = '0;
    logic y_ready = 1'b0;

    logic [15:0] wm [N];
    logic [15:0] xm [N];

    int checks = 0;
    int errors = 0;

    neuron_mac_sequencer_if #(.AW(5), .DW(16)) bus_r ();
    neuron_mac_sequencer_if #(.AW(5), .DW(16)) bus_l ();

    neuron_mac_sequencer #(.RELU(1'b1)) dut_r (.clk(clk), .rst(rst), .bus(bus_r));
    neuron_mac_sequencer #(.RELU(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

    always #5 clk = ~clk;

    assign bus_r.start   = start;
    assign bus_l.start   = start;
    assign bus_r.bias    = bias_v;
    assign bus_l.bias    = bias_v;
    assign bus_r.y_ready = y_ready;
    assign bus_l.y_ready = y_ready;

    initial begin
        bus_r.w_do = '0; bus_r.x_do = '0;
        bus_l.w_do = '0; bus_l.x_do = '0;
    end

    // negedge-read BRAM models
    always @(negedge clk) begin
        if (bus_r.w_en) bus_r.w_do = wm[bus_r.w_addr];
        if (bus_r.x_en) bus_r.x_do = xm[bus_r.x_addr];
        if (bus_l.w_en) bus_l.w_do = wm[bus_l.w_addr];
        if (bus_l.x_en) bus_l.x_do = xm[bus_l.x_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] b, input bit relu);
        longint s;
        s = 0;
        for (int i = 0; i < N; i++) s += longint'($signed(wm[i])) * longint'($signed(xm[i]));
        s += longint'($signed(b)) * 256;
        s = s >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return s[15:0];
    endfunction

    task automatic fill(input logic [15:0] w, input logic [15:0] x);
        for (int i = 0; i < N; i++) begin
            wm[i] = w;
            xm[i] = x;
        end
    endtask

    task automatic start_op(input logic [15:0] b);
        @(negedge clk);
        bias_v = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bias_v = 16'($urandom);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_y"}, {16'd0, bus_r.y, bus_l.y}, 32'd0);
        chk({tag, "_ctl"}, {24'd0, bus_r.y_valid, bus_l.y_valid, bus_r.busy, bus_l.busy,
                            bus_r.w_en, bus_r.x_en, bus_l.w_en, bus_l.x_en}, 32'd0);
        chk({tag, "_addr"}, {12'd0, bus_r.w_addr, bus_r.x_addr, bus_l.w_addr, bus_l.x_addr}, 32'd0);
    endtask

    task automatic run_op(input string name, input logic [15:0] b, input int hold);
        logic [15:0] exp_r, exp_l, y_r0, y_l0;
        int lat, en_cnt, addr_bad, side_bad;
        exp_r = model(b, 1'b1);
        exp_l = model(b, 1'b0);
        lat = 0; en_cnt = 0; addr_bad = 0; side_bad = 0;
        start_op(b);
        forever begin
            if (bus_r.w_en) begin
                if (bus_r.w_addr != 5'(en_cnt)) addr_bad++;
                en_cnt++;
            end
            if (bus_r.x_addr != bus_r.w_addr || bus_r.x_en != bus_r.w_en) side_bad++;
            if (bus_l.w_addr != bus_r.w_addr || bus_l.w_en != bus_r.w_en) side_bad++;
            if (bus_r.w_we || bus_l.w_we || !bus_r.busy || !bus_l.busy) side_bad++;
            if (bus_r.y_valid || lat >= 100) break;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_latency"}, lat, 30);
        chk({name, "_en_cycles"}, en_cnt, N);
        chk({name, "_addr_seq"}, addr_bad, 0);
        chk({name, "_port_rules"}, side_bad, 0);
        chk({name, "_y_relu"}, {16'd0, bus_r.y}, {16'd0, exp_r});
        chk({name, "_y_lin"}, {15'd0, bus_l.y_valid, bus_l.y}, {15'd0, 1'b1, exp_l});
        if (hold > 0) begin
            y_r0 = bus_r.y;
            y_l0 = bus_l.y;
            start = 1'b1;
            for (int c = 0; c < hold; c++) begin
                @(posedge clk);
                #1;
                chk({name, "_hold_y"}, {bus_r.y, bus_l.y}, {y_r0, y_l0});
                chk({name, "_hold_ctl"}, {28'd0, bus_r.y_valid, bus_r.busy, bus_l.busy,
                                          bus_r.w_en | bus_l.w_en}, {28'd0, 4'b1110});
            end
        end
        y_ready = 1'b1;
        @(posedge clk);
        #1;
        y_ready = 1'b0;
        start = 1'b0;
        chk({name, "_handshake"}, {28'd0, bus_r.y_valid, bus_l.y_valid, bus_r.busy, bus_l.busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_idle_after"}, {30'd0, bus_r.busy | bus_l.busy, bus_r.w_en | bus_l.w_en}, 32'd0);
    endtask

    initial begin
        int guard;
        fill(16'h0000, 16'h0000);
        #2;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        fill(16'h0100, 16'h0100);
        run_op("t1_ones", 16'h0000, 0);
        chk("t1_value", {16'd0, bus_l.y}, 32'h1C00);

        fill(16'h7FFF, 16'h7FFF);
        run_op("t2_possat", 16'h7FFF, 0);
        chk("t2_value", {16'd0, bus_r.y}, 32'h7FFF);

        fill(16'hFF00, 16'h0100);
        run_op("t3_neg", 16'h0000, 0);
        chk("t3_value", {bus_r.y, bus_l.y}, 32'h0000_E400);

        fill(16'h0000, 16'h0000);
        wm[0] = 16'hFFFF;
        xm[0] = 16'h0001;
        run_op("t4_floor", 16'h0000, 0);
        chk("t4_value", {bus_r.y, bus_l.y}, 32'h0000_FFFF);

        fill(16'h8000, 16'h7FFF);
        run_op("negsat", 16'h8000, 0);

        fill(16'h0100, 16'h0200);
        run_op("t5_hold", 16'hFF80, 10);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                if (r % 2 == 0) begin
                    wm[i] = 16'($urandom_range(0, 1023)) - 16'd512;
                    xm[i] = 16'($urandom_range(0, 1023)) - 16'd512;
                end else begin
                    wm[i] = 16'($urandom);
                    xm[i] = 16'($urandom);
                end
            end
            run_op($sformatf("rand%0d", r), 16'($urandom), (r == 3) ? 3 : 0);
        end

        fill(16'h0100, 16'h0100);
        start_op(16'h0000);
        guard = 0;
        while (bus_r.w_addr != 5'd13 && guard < 60) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("t6_reach_addr13", {31'd0, bus_r.w_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("t6_async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("t6_no_partial_y", {30'd0, bus_r.y_valid, bus_l.y_valid}, 32'd0);
        run_op("t6_restart", 16'h0000, 0);
        chk("t6_value", {bus_r.y, bus_l.y}, 32'h1C00_1C00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
